mxm_rd_arb: RTL and testbench
=============================

// Module: mxm_rd_arb
// PURPOSE
//  Shares the single read port of the MXM simple-dual-port URAM between two read requesters.
//  Arbitration is round-robin. Each accepted read is tracked through the memory's fixed
//  read-latency pipeline, and the returned word is steered to the requester that issued it.
//  The write port passes through from the single writer. Reads are held off on a same-cycle
//  address collision with a write, so a read always returns post-write data.
//  Sits between the MXM consumers (compute/store paths) and mxm_mem.
// PARAMETERS
//  DATA_WIDTH  256   word width; equals mxm_mem data width (`P*2*8)
//  DEPTH       4096  words; equals `MXM_DEPTH
//  ADDR_WIDTH  12    $clog2(DEPTH)
//  RD_LAT      3     cycles from mem rd_en to valid mem dout; equals mxm_mem read latency
// PORTS
//  clk          in   1           clock
//  rstn         in   1           async active-low reset
//  rd0_vld      in   1           requester 0 read request
//  rd0_addr     in   ADDR_WIDTH  requester 0 read address
//  rd0_rdy      out  1           requester 0 request accepted this cycle
//  rd1_vld      in   1           requester 1 read request
//  rd1_addr     in   ADDR_WIDTH  requester 1 read address
//  rd1_rdy      out  1           requester 1 request accepted this cycle
//  rsp0_vld     out  1           read data for requester 0 on rsp_data
//  rsp1_vld     out  1           read data for requester 1 on rsp_data
//  rsp_data     out  DATA_WIDTH  returned word (shared bus, qualified by rspN_vld)
//  wr_en        in   1           write request; always accepted
//  wr_addr      in   ADDR_WIDTH  write address
//  wr_data      in   DATA_WIDTH  write data
//  mem_rd_en    out  1           to mxm_mem rd_en
//  mem_rd_addr  out  ADDR_WIDTH  to mxm_mem rd_addr
//  mem_dout     in   DATA_WIDTH  from mxm_mem dout
//  mem_wr_en    out  1           to mxm_mem wr_en (= wr_en, combinational)
//  mem_wr_addr  out  ADDR_WIDTH  = wr_addr
//  mem_wr_data  out  DATA_WIDTH  = wr_data
//  idle         out  1           no read in flight and no request pending
// BEHAVIOUR
//  - Reset (rstn=0, async): rr_ptr=0; tag pipe cleared; outstanding count=0.
//    rsp0_vld=rsp1_vld=0, rdN_rdy=0, mem_rd_en=0, idle=1. In-flight reads are dropped
//    and never reported.
//  - Hazard: hz = wr_en && (candidate rd addr == wr_addr). A hazarded candidate is not
//    granted this cycle. The other requester may still be granted if it is not hazarded.
//  - Grant (combinational, one per cycle). Eligible_N = rdN_vld && !hzN.
//    * One eligible: grant it.
//    * Both eligible: grant port rr_ptr.
//    * rr_ptr <= ~granted_id on every grant; unchanged otherwise.
//  - rdN_rdy = grantN. Accept = vld&&rdy. mem_rd_en = any grant.
//    mem_rd_addr = granted address; 0 when none.
//  - Tag pipe: RD_LAT-stage shift register of {v,id}. Stage 0 loads {mem_rd_en, granted_id}.
//    At the output stage: rsp0_vld = v && id==0, rsp1_vld = v && id==1.
//    rsp_data = mem_dout, combinational.
//  - Latency: response exactly RD_LAT cycles after the accept cycle.
//    Throughput 1 read/cycle; responses are in order; no response backpressure.
//  - Outstanding count width $clog2(RD_LAT+1): +1 on accept, -1 on response, both on the
//    same cycle -> unchanged. idle = (count==0) && !rd0_vld && !rd1_vld.
//  - Requesters hold vld/addr stable until rdy. Dropping vld before rdy is legal and
//    cancels the request.
//  - Addresses are not range-checked. Addresses >= DEPTH are passed through unchanged.
// TESTING
//  1. Single read: rd0 addr 5 (mem[5]=0xA5) -> rd0_rdy same cycle; rsp0_vld 1 cycle,
//     3 cycles later, data 0xA5; rsp1_vld stays 0.
//  2. Contention: rd0 and rd1 both vld for 4 cycles after reset -> grants 0,1,0,1;
//     responses interleave with matching ids.
//  3. Hazard: wr_en addr 7 data 0x77 while rd0 addr 7 -> rd0_rdy=0 that cycle, granted
//     next; returns 0x77. Same cycle, rd1 addr 8 is granted.
//  4. Back-to-back: rd1 addrs 0..15 streamed -> 16 consecutive rsp1_vld in address
//     order; idle=0 throughout, returns to 1 after the last response.
//  5. Reset mid-op: rstn low with 2 reads in flight -> no rsp after reset release;
//     idle=1, rr_ptr=0 (first contention grants port 0).
//  6. Withdraw: rd1_vld pulses 1 cycle while blocked by hazard -> no grant, no response,
//     count unchanged.

Source files
------------

// File: rtl/mxm_rd_arb_if.sv
// Bundle of the read-requester, writer and mxm_mem-side signals of mxm_rd_arb.
//
// Handshake: a requester raises rdN_vld with a stable rdN_addr and keeps both
// unchanged until it sees rdN_rdy high in the same cycle; that cycle is the
// accept (vld && rdy). Dropping rdN_vld before rdy withdraws the request.
// Responses (rspN_vld + rsp_data) have no backpressure: they appear exactly
// RD_LAT cycles after the accept. Writes (wr_en) are always accepted.
interface mxm_rd_arb_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 12
);
  logic                  rd0_vld;
  logic [ADDR_WIDTH-1:0] rd0_addr;
  logic                  rd0_rdy;
  logic                  rd1_vld;
  logic [ADDR_WIDTH-1:0] rd1_addr;
  logic                  rd1_rdy;
  logic                  rsp0_vld;
  logic                  rsp1_vld;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  idle;

  // Arbiter side
  modport slave (
    input  rd0_vld, rd0_addr, rd1_vld, rd1_addr, wr_en, wr_addr, wr_data, mem_dout,
    output rd0_rdy, rd1_rdy, rsp0_vld, rsp1_vld, rsp_data,
           mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, idle
  );

  // Requesters / writer / memory side
  modport master (
    output rd0_vld, rd0_addr, rd1_vld, rd1_addr, wr_en, wr_addr, wr_data, mem_dout,
    input  rd0_rdy, rd1_rdy, rsp0_vld, rsp1_vld, rsp_data,
           mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, idle
  );
endinterface

// File: rtl/mxm_rd_arb.sv
// Round-robin arbiter for the single read port of the MXM URAM.
// Two requesters share the read port; each granted read is tagged with the
// requester id and the tag travels alongside the memory's fixed read latency,
// so the returned word is flagged for the right requester. A read that hits
// the address being written in the same cycle is held off one cycle so it
// always observes post-write data. The write port is a plain pass-through.
module mxm_rd_arb #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LAT     = 3
) (
  input logic          clk,
  input logic          rstn,
  mxm_rd_arb_if.slave  bus
);
  localparam int CNT_W = $clog2(RD_LAT + 1);

  logic                  rr_ptr;     // port preferred when both are eligible
  logic [RD_LAT-1:0]     tag_v;      // stage valid
  logic [RD_LAT-1:0]     tag_id;     // stage requester id
  logic [CNT_W-1:0]      out_cnt;    // reads issued and not yet returned

  logic                  hz0, hz1;
  logic                  el0, el1;
  logic                  gnt0, gnt1;
  logic                  any_gnt;
  logic                  gnt_id;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic                  rsp_v;
  logic [DATA_WIDTH-1:0] rd_word;

  // Hazard detection and one-hot grant selection
  always_comb begin
    hz0      = bus.wr_en && (bus.rd0_addr == bus.wr_addr);
    hz1      = bus.wr_en && (bus.rd1_addr == bus.wr_addr);
    el0      = bus.rd0_vld && !hz0;
    el1      = bus.rd1_vld && !hz1;
    gnt0     = rstn && el0 && (!el1 || !rr_ptr);
    gnt1     = rstn && el1 && (!el0 ||  rr_ptr);
    any_gnt  = gnt0 || gnt1;
    gnt_id   = gnt1;
    gnt_addr = '0;
    if (gnt1) begin
      gnt_addr = bus.rd1_addr;
    end else if (gnt0) begin
      gnt_addr = bus.rd0_addr;
    end
  end

  assign rsp_v   = tag_v[RD_LAT-1];
  assign rd_word = bus.mem_dout;

  assign bus.rd0_rdy     = gnt0;
  assign bus.rd1_rdy     = gnt1;
  assign bus.mem_rd_en   = any_gnt;
  assign bus.mem_rd_addr = gnt_addr;
  assign bus.rsp0_vld    = rsp_v && !tag_id[RD_LAT-1];
  assign bus.rsp1_vld    = rsp_v &&  tag_id[RD_LAT-1];
  assign bus.rsp_data    = rd_word;
  assign bus.mem_wr_en   = bus.wr_en;
  assign bus.mem_wr_addr = bus.wr_addr;
  assign bus.mem_wr_data = bus.wr_data;
  assign bus.idle        = (out_cnt == '0) && !bus.rd0_vld && !bus.rd1_vld;

  // Round-robin pointer: after a grant, the other port is preferred
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= 1'b0;
    end else if (any_gnt) begin
      rr_ptr <= ~gnt_id;
    end
  end

  // Tag pipe shadowing the memory read latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= any_gnt;
      tag_id[0] <= gnt_id;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  // Outstanding-read counter feeding the idle flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_cnt <= '0;
    end else begin
      case ({any_gnt, rsp_v})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_mxm_rd_arb.sv
// Bench for mxm_rd_arb: a behavioural memory with a 3-cycle read pipe sits on
// the mem_* side; a cycle-level reference model predicts grants, responses,
// idle and pass-through values and is compared every cycle.
module tb_mxm_rd_arb;
  localparam int DW     = 256;
  localparam int AW     = 12;
  localparam int DEPTH  = 4096;
  localparam int RD_LAT = 3;

  logic clk = 1'b0;
  logic rstn;

  mxm_rd_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mxm_rd_arb #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_LAT(RD_LAT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory environment ----------------
  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] pipe [RD_LAT];

  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    pipe[0] <= mem[bus.mem_rd_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_dout = pipe[RD_LAT-1];

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q[$];    // expected response data, in order
  int            id_q[$];     // expected requester id per response
  int            due_q[$];    // cycle number the response is due
  int            cyc;         // model cycle number
  int            pref;        // requester that wins a tie
  int            n_chk;
  int            n_fail;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: apply inputs, check everything the model predicts, then
  // advance the model across the clock edge.
  task automatic drive_cycle(
    input  logic          v0, input logic [AW-1:0] a0,
    input  logic          v1, input logic [AW-1:0] a1,
    input  logic          we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
    output logic          g0, output logic g1
  );
    logic          e0, e1, r0, r1;
    logic [DW-1:0] rd;
    logic [AW-1:0] ea;
    int            id;
    @(negedge clk);
    bus.rd0_vld = v0; bus.rd0_addr = a0;
    bus.rd1_vld = v1; bus.rd1_addr = a1;
    bus.wr_en   = we; bus.wr_addr  = wa; bus.wr_data = wd;
    #1;
    e0 = v0 && !(we && (a0 == wa));
    e1 = v1 && !(we && (a1 == wa));
    if (e0 && e1) begin
      g0 = (pref == 0);
      g1 = (pref == 1);
    end else begin
      g0 = e0;
      g1 = e1;
    end
    ea = g0 ? a0 : (g1 ? a1 : '0);
    check("rd0_rdy",     DW'(bus.rd0_rdy),     DW'(g0));
    check("rd1_rdy",     DW'(bus.rd1_rdy),     DW'(g1));
    check("mem_rd_en",   DW'(bus.mem_rd_en),   DW'(g0 || g1));
    check("mem_rd_addr", DW'(bus.mem_rd_addr), DW'(ea));
    check("mem_wr_en",   DW'(bus.mem_wr_en),   DW'(we));
    check("mem_wr_addr", DW'(bus.mem_wr_addr), DW'(wa));
    check("mem_wr_data", bus.mem_wr_data,      wd);
    check("idle",        DW'(bus.idle),        DW'((exp_q.size() == 0) && !v0 && !v1));
    r0 = 1'b0; r1 = 1'b0; rd = '0;
    if (exp_q.size() > 0 && due_q[0] == cyc) begin
      rd = exp_q.pop_front();
      id = id_q.pop_front();
      void'(due_q.pop_front());
      r0 = (id == 0);
      r1 = (id == 1);
    end
    check("rsp0_vld", DW'(bus.rsp0_vld), DW'(r0));
    check("rsp1_vld", DW'(bus.rsp1_vld), DW'(r1));
    if (r0 || r1) check("rsp_data", bus.rsp_data, rd);
    if (g0 || g1) begin
      exp_q.push_back(ref_mem[ea]);
      id_q.push_back(g1 ? 1 : 0);
      due_q.push_back(cyc + RD_LAT);
      pref = g0 ? 1 : 0;
    end
    if (we) ref_mem[wa] = wd;
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    logic g0, g1;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, g0, g1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.rd0_vld = 1'b0; bus.rd0_addr = '0;
    bus.rd1_vld = 1'b0; bus.rd1_addr = '0;
    bus.wr_en   = 1'b0; bus.wr_addr  = '0; bus.wr_data = '0;
    rstn = 1'b0;
    exp_q.delete(); id_q.delete(); due_q.delete();
    pref = 0;
    #1;
    check("rst_idle",     DW'(bus.idle),      DW'(1));
    check("rst_rsp0",     DW'(bus.rsp0_vld),  DW'(0));
    check("rst_rsp1",     DW'(bus.rsp1_vld),  DW'(0));
    check("rst_mem_rden", DW'(bus.mem_rd_en), DW'(0));
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic          g0, g1;
    logic          p0v, p1v, we;
    logic [AW-1:0] p0a, p1a, wa;
    logic [DW-1:0] wd;
    n_chk = 0; n_fail = 0; cyc = 0; pref = 0;
    rstn = 1'b0;
    do_reset();

    // Preload addresses 0..31 through the write port
    for (int i = 0; i < 32; i++) begin
      wd = {8{$urandom}};
      if (i == 5) wd = DW'(8'hA5);
      drive_cycle(1'b0, '0, 1'b0, '0, 1'b1, AW'(i), wd, g0, g1);
    end

    // Single read of address 5
    drive_cycle(1'b1, AW'(5), 1'b0, '0, 1'b0, '0, '0, g0, g1);
    idle_cycles(5);

    // Contention right after a reset: expect 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, AW'(10 + i), 1'b1, AW'(20 + i), 1'b0, '0, '0, g0, g1);
    idle_cycles(5);

    // Hazard: rd0 collides with write to 7, rd1 at 8 goes through
    drive_cycle(1'b1, AW'(7), 1'b1, AW'(8), 1'b1, AW'(7), DW'(8'h77), g0, g1);
    check("hz_rd0_blocked", DW'(g0), DW'(0));
    drive_cycle(1'b1, AW'(7), 1'b0, '0, 1'b0, '0, '0, g0, g1);
    idle_cycles(5);

    // Back-to-back stream on requester 1
    for (int i = 0; i < 16; i++) drive_cycle(1'b0, '0, 1'b1, AW'(i), 1'b0, '0, '0, g0, g1);
    idle_cycles(5);

    // Reset with two reads in flight, then contention must favour port 0
    drive_cycle(1'b1, AW'(1), 1'b0, '0, 1'b0, '0, '0, g0, g1);
    drive_cycle(1'b1, AW'(2), 1'b0, '0, 1'b0, '0, '0, g0, g1);
    do_reset();
    idle_cycles(5);
    drive_cycle(1'b1, AW'(3), 1'b1, AW'(4), 1'b0, '0, '0, g0, g1);
    check("post_rst_first_gnt0", DW'(g0), DW'(1));
    idle_cycles(5);

    // Withdraw while hazarded: no grant, nothing outstanding
    drive_cycle(1'b0, '0, 1'b1, AW'(9), 1'b1, AW'(9), {8{$urandom}}, g0, g1);
    idle_cycles(5);

    // Randomized traffic with holds, withdrawals and colliding writes
    p0v = 1'b0; p1v = 1'b0; p0a = '0; p1a = '0;
    for (int n = 0; n < 600; n++) begin
      if (!p0v) begin
        p0v = ($urandom_range(0, 99) < 60);
        p0a = AW'($urandom_range(0, 31));
      end else if ($urandom_range(0, 9) == 0) begin
        p0v = 1'b0;
      end
      if (!p1v) begin
        p1v = ($urandom_range(0, 99) < 60);
        p1a = AW'($urandom_range(0, 31));
      end else if ($urandom_range(0, 9) == 0) begin
        p1v = 1'b0;
      end
      we = ($urandom_range(0, 2) == 0);
      wa = AW'($urandom_range(0, 31));
      wd = {8{$urandom}};
      drive_cycle(p0v, p0a, p1v, p1a, we, wa, wd, g0, g1);
      if (g0) p0v = 1'b0;
      if (g1) p1v = 1'b0;
    end
    idle_cycles(6);
    check("drained", DW'(exp_q.size()), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
